// File: rtl/complex_matmul_nxn_accel_pkg.sv
// rtl/complex_matmul_nxn_accel_pkg.sv - shared constants, FSM states and widths for the matmul accelerator
package matmul_pkg;

   // Word addresses and bank selectors (address[8:7])
   localparam logic [8:0] CTRL_ADDR   = 9'h000;
   localparam logic [8:0] STATUS_ADDR = 9'h001;
   localparam logic [1:0] BANK_CSR    = 2'd0;
   localparam logic [1:0] BANK_A      = 2'd1;  // 0x080
   localparam logic [1:0] BANK_B      = 2'd2;  // 0x100
   localparam logic [1:0] BANK_C      = 2'd3;  // 0x180

   // CTRL bit indices
   localparam int CTRL_START    = 0;
   localparam int CTRL_DONE_CLR = 1;
   localparam int CTRL_IRQ_EN   = 2;

   // STATUS bit indices
   localparam int ST_BUSY   = 0;
   localparam int ST_DONE   = 1;
   localparam int ST_OVF    = 2;
   localparam int ST_IRQ_EN = 3;
   localparam int ST_N_LSB  = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MAC,
      S_WB
   } state_e;

   // Four guard bits cover the sum of up to 8 complex products pairs
   function automatic int acc_w(input int width);
      return 2 * width + 4;
   endfunction

endpackage

// File: rtl/complex_matmul_nxn_accel_if.sv
// rtl/complex_matmul_nxn_accel_if.sv - Avalon-MM slave bus bundle for the matmul accelerator
interface complex_matmul_nxn_accel_if;
   logic        write;
   logic        read;
   logic [8:0]  address;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (
      output write, read, address, writedata,
      input  readdata, irq
   );

   modport slave (
      input  write, read, address, writedata,
      output readdata, irq
   );
endinterface

// File: rtl/complex_matmul_nxn_accel_complex_mac.sv
// rtl/complex_matmul_nxn_accel_complex_mac.sv - registered complex MAC with shifted, saturated output
module complex_mac
   import matmul_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int FRAC  = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] ar_i,
   input  logic [WIDTH-1:0] ai_i,
   input  logic [WIDTH-1:0] br_i,
   input  logic [WIDTH-1:0] bi_i,
   output logic [WIDTH-1:0] re_o,
   output logic [WIDTH-1:0] im_o,
   output logic             ovf_o
);
   localparam int AW = acc_w(WIDTH);
   localparam int PW = 2 * WIDTH;

   logic signed [PW-1:0] ar_x, ai_x, br_x, bi_x;
   logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [AW-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
   logic signed [AW-1:0] sh_re, sh_im;
   logic                 ovf_re, ovf_im;

   // Returns {overflow, clamped value}; in range when all bits above the sign agree
   function automatic logic [WIDTH:0] sat(input logic [AW-1:0] v);
      logic [AW-WIDTH:0] top;
      top = v[AW-1:WIDTH-1];
      if ((&top) || (~|top)) return {1'b0, v[WIDTH-1:0]};
      return {1'b1, v[AW-1], {(WIDTH-1){~v[AW-1]}}};
   endfunction

   assign ar_x = {{WIDTH{ar_i[WIDTH-1]}}, ar_i};
   assign ai_x = {{WIDTH{ai_i[WIDTH-1]}}, ai_i};
   assign br_x = {{WIDTH{br_i[WIDTH-1]}}, br_i};
   assign bi_x = {{WIDTH{bi_i[WIDTH-1]}}, bi_i};

   assign p_rr = ar_x * br_x;
   assign p_ii = ai_x * bi_x;
   assign p_ri = ar_x * bi_x;
   assign p_ir = ai_x * br_x;

   assign acc_re_d = acc_re_q + {{4{p_rr[PW-1]}}, p_rr} - {{4{p_ii[PW-1]}}, p_ii};
   assign acc_im_d = acc_im_q + {{4{p_ri[PW-1]}}, p_ri} + {{4{p_ir[PW-1]}}, p_ir};

   assign sh_re = acc_re_q >>> FRAC;
   assign sh_im = acc_im_q >>> FRAC;

   assign {ovf_re, re_o} = sat(sh_re);
   assign {ovf_im, im_o} = sat(sh_im);
   assign ovf_o          = ovf_re | ovf_im;

   // Accumulator: clear wins over accumulate
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_re_q <= '0;
         acc_im_q <= '0;
      end else if (clr_i) begin
         acc_re_q <= '0;
         acc_im_q <= '0;
      end else if (en_i) begin
         acc_re_q <= acc_re_d;
         acc_im_q <= acc_im_d;
      end
   end

endmodule

// File: rtl/complex_matmul_nxn_accel.sv
// rtl/complex_matmul_nxn_accel.sv - sequential NxN complex matrix multiplier with CSR/bank slave port
module complex_matmul_nxn_accel
   import matmul_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int FRAC  = 0
) (
   input  logic                         clk,
   input  logic                         reset_n,
   complex_matmul_nxn_accel_if.slave    bus
);
   localparam int WORDS = 2 * N * N;
   localparam int DW    = $clog2(WORDS);

   logic [WIDTH-1:0] a_q [WORDS];
   logic [WIDTH-1:0] b_q [WORDS];
   logic [WIDTH-1:0] c_q [WORDS];

   state_e      state_q, state_d;
   logic [3:0]  i_q, i_d, j_q, j_d, k_q, k_d;
   logic        done_q, ovf_q, irq_en_q;
   logic [31:0] rdata_q, rdata_d, status;

   logic          busy, ctrl_wr, start_req, bank_hit;
   logic          mac_en, mac_clr, wb_en, fin;
   logic [DW-1:0] bus_idx, a_idx, b_idx, c_idx;
   logic [DW-1:0] a_im_idx, b_im_idx, c_im_idx;
   logic [WIDTH-1:0] res_re, res_im;
   logic             mac_ovf;

   function automatic logic [31:0] sext(input logic [WIDTH-1:0] v);
      return 32'($signed(v));
   endfunction

   assign busy      = (state_q != S_IDLE);
   assign ctrl_wr   = bus.write && (bus.address == CTRL_ADDR);
   assign start_req = ctrl_wr && bus.writedata[CTRL_START] && !busy;
   assign bank_hit  = (int'(bus.address[6:0]) < WORDS);
   assign bus_idx   = bus.address[DW-1:0];

   assign a_idx    = DW'(2 * (int'(i_q) * N + int'(k_q)));
   assign b_idx    = DW'(2 * (int'(k_q) * N + int'(j_q)));
   assign c_idx    = DW'(2 * (int'(i_q) * N + int'(j_q)));
   assign a_im_idx = {a_idx[DW-1:1], 1'b1};
   assign b_im_idx = {b_idx[DW-1:1], 1'b1};
   assign c_im_idx = {c_idx[DW-1:1], 1'b1};

   complex_mac #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mac (
      .clk     (clk),
      .reset_n (reset_n),
      .clr_i   (mac_clr),
      .en_i    (mac_en),
      .ar_i    (a_q[a_idx]),
      .ai_i    (a_q[a_im_idx]),
      .br_i    (b_q[b_idx]),
      .bi_i    (b_q[b_im_idx]),
      .re_o    (res_re),
      .im_o    (res_im),
      .ovf_o   (mac_ovf)
   );

   // FSM and i/j/k counter registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
      end
   end

   // Next state: N MAC cycles per element, then one write-back cycle
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      mac_en  = 1'b0;
      mac_clr = 1'b0;
      wb_en   = 1'b0;
      fin     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_req) begin
               state_d = S_MAC;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
               mac_clr = 1'b1;
            end
         end
         S_MAC: begin
            mac_en = 1'b1;
            if (k_q == 4'(N - 1)) begin
               state_d = S_WB;
               k_d     = '0;
            end else begin
               k_d = k_q + 4'd1;
            end
         end
         S_WB: begin
            wb_en   = 1'b1;
            mac_clr = 1'b1;
            state_d = S_MAC;
            if (j_q == 4'(N - 1)) begin
               j_d = '0;
               if (i_q == 4'(N - 1)) begin
                  i_d     = '0;
                  state_d = S_IDLE;
                  fin     = 1'b1;
               end else begin
                  i_d = i_q + 4'd1;
               end
            end else begin
               j_d = j_q + 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Matrix banks: host writes to A/B only while idle; C owned by the engine
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int e = 0; e < WORDS; e++) begin
            a_q[e] <= '0;
            b_q[e] <= '0;
            c_q[e] <= '0;
         end
      end else begin
         if (bus.write && !busy && bank_hit) begin
            if (bus.address[8:7] == BANK_A) a_q[bus_idx] <= bus.writedata[WIDTH-1:0];
            if (bus.address[8:7] == BANK_B) b_q[bus_idx] <= bus.writedata[WIDTH-1:0];
         end
         if (start_req) begin
            for (int e = 0; e < WORDS; e++) c_q[e] <= '0;
         end else if (wb_en) begin
            c_q[c_idx]    <= res_re;
            c_q[c_im_idx] <= res_im;
         end
      end
   end

   // Control/status flags: start clears, completion sets done, overflow is sticky
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         irq_en_q <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            irq_en_q <= bus.writedata[CTRL_IRQ_EN];
            if (bus.writedata[CTRL_DONE_CLR]) done_q <= 1'b0;
         end
         if (start_req) begin
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
         end
         if (wb_en && mac_ovf) ovf_q <= 1'b1;
         if (fin) done_q <= 1'b1;
      end
   end

   // Read mux; readdata holds when no read is issued
   always_comb begin
      status               = '0;
      status[ST_BUSY]      = busy;
      status[ST_DONE]      = done_q;
      status[ST_OVF]       = ovf_q;
      status[ST_IRQ_EN]    = irq_en_q;
      status[ST_N_LSB +: 4] = 4'(N);
      rdata_d = rdata_q;
      if (bus.read) begin
         rdata_d = '0;
         case (bus.address[8:7])
            BANK_CSR: if (bus.address == STATUS_ADDR) rdata_d = status;
            BANK_A:   if (bank_hit) rdata_d = sext(a_q[bus_idx]);
            BANK_B:   if (bank_hit) rdata_d = sext(b_q[bus_idx]);
            BANK_C:   if (bank_hit) rdata_d = sext(c_q[bus_idx]);
         endcase
      end
   end

   // Registered read data
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rdata_q <= '0;
      else          rdata_q <= rdata_d;
   end

   assign bus.readdata = rdata_q;
   assign bus.irq      = done_q & irq_en_q;

endmodule
